// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Brief    : Parametrised VGA timing generator with pixel-step enable, camera
//            read-request lead, blur-border flag and a sync/blank alignment pipe.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int H_ACT      = 640,
    parameter int H_FP       = 16,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int V_ACT      = 480,
    parameter int V_FP       = 10,
    parameter bit HS_POL     = 1'b0,
    parameter bit VS_POL     = 1'b0,
    parameter int READ_LEAD  = 1,
    parameter int PIPE_DEPTH = 3,
    parameter int PAD        = 2,
    parameter int COORD_W    = 13
) (
    input  logic               CLOCK_50,
    input  logic               RESET_N,
    input  logic               pix_ce,
    input  logic               soft_clear,
    output logic               VGA_HS,
    output logic               VGA_VS,
    output logic               VGA_BLANK_N,
    output logic               orequest,
    output logic [COORD_W-1:0] col,
    output logic [COORD_W-1:0] row,
    output logic               active,
    output logic               pad,
    output logic               line_start,
    output logic               frame_start,
    output logic [15:0]        frame_count
);

    localparam logic [COORD_W-1:0] c_h_sync = COORD_W'(H_SYNC);
    localparam logic [COORD_W-1:0] c_h_beg  = COORD_W'(H_SYNC + H_BP);
    localparam logic [COORD_W-1:0] c_h_end  = COORD_W'(H_SYNC + H_BP + H_ACT);
    localparam logic [COORD_W-1:0] c_h_last = COORD_W'(H_SYNC + H_BP + H_ACT + H_FP - 1);
    localparam logic [COORD_W-1:0] c_v_sync = COORD_W'(V_SYNC);
    localparam logic [COORD_W-1:0] c_v_beg  = COORD_W'(V_SYNC + V_BP);
    localparam logic [COORD_W-1:0] c_v_end  = COORD_W'(V_SYNC + V_BP + V_ACT);
    localparam logic [COORD_W-1:0] c_v_last = COORD_W'(V_SYNC + V_BP + V_ACT + V_FP - 1);
    localparam logic [COORD_W:0]   c_lead   = (COORD_W+1)'(READ_LEAD);
    localparam logic [COORD_W-1:0] c_pad    = COORD_W'(PAD);
    localparam logic [COORD_W-1:0] c_col_hi = COORD_W'(H_ACT - PAD);
    localparam logic [COORD_W-1:0] c_row_hi = COORD_W'(V_ACT - PAD);
    localparam logic [PIPE_DEPTH:0] c_hs_idle    = {(PIPE_DEPTH+1){~HS_POL}};
    localparam logic [PIPE_DEPTH:0] c_vs_idle    = {(PIPE_DEPTH+1){~VS_POL}};
    localparam logic [PIPE_DEPTH:0] c_blank_idle = '0;

    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
    logic [COORD_W-1:0] col_q, col_d, row_q, row_d;
    logic               active_q, active_d, pad_q, pad_d, orequest_q, orequest_d;
    logic               line_start_q, line_start_d, frame_start_q, frame_start_d;
    logic [15:0]        frame_count_q, frame_count_d;
    logic [PIPE_DEPTH:0] hs_pipe_q, hs_pipe_d, vs_pipe_q, vs_pipe_d;
    logic [PIPE_DEPTH:0] blank_pipe_q, blank_pipe_d;

    logic               hs_raw, vs_raw, h_act, v_act, act, req_raw, pad_raw;
    logic [COORD_W:0]   x_lead;
    logic [COORD_W-1:0] col_raw, row_raw;

    always_comb begin
        hs_raw  = (x_q < c_h_sync);
        vs_raw  = (y_q < c_v_sync);
        h_act   = (x_q >= c_h_beg) && (x_q < c_h_end);
        v_act   = (y_q >= c_v_beg) && (y_q < c_v_end);
        act     = h_act && v_act;
        // Look-ahead stays on the current line, so the request never leaks
        // into vertical blanking.
        x_lead  = {1'b0, x_q} + c_lead;
        req_raw = v_act && (x_lead >= {1'b0, c_h_beg}) && (x_lead < {1'b0, c_h_end});
        col_raw = act ? (x_q - c_h_beg) : '0;
        row_raw = act ? (y_q - c_v_beg) : '0;
        pad_raw = act && ((col_raw < c_pad) || (col_raw >= c_col_hi) ||
                          (row_raw < c_pad) || (row_raw >= c_row_hi));
    end

    always_comb begin
        x_d           = x_q;
        y_d           = y_q;
        col_d         = col_q;
        row_d         = row_q;
        active_d      = active_q;
        pad_d         = pad_q;
        orequest_d    = orequest_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        frame_count_d = frame_count_q;
        hs_pipe_d     = hs_pipe_q;
        vs_pipe_d     = vs_pipe_q;
        blank_pipe_d  = blank_pipe_q;

        if (soft_clear) begin
            x_d          = '0;
            y_d          = '0;
            col_d        = '0;
            row_d        = '0;
            active_d     = 1'b0;
            pad_d        = 1'b0;
            orequest_d   = 1'b0;
            hs_pipe_d    = c_hs_idle;
            vs_pipe_d    = c_vs_idle;
            blank_pipe_d = c_blank_idle;
        end else if (pix_ce) begin
            if (x_q == c_h_last) begin
                x_d = '0;
                y_d = (y_q == c_v_last) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
            col_d         = col_raw;
            row_d         = row_raw;
            active_d      = act;
            pad_d         = pad_raw;
            orequest_d    = req_raw;
            line_start_d  = (x_q == '0);
            frame_start_d = (x_q == '0) && (y_q == '0);
            if (frame_start_d)
                frame_count_d = frame_count_q + 16'd1;
            hs_pipe_d[0]    = hs_raw ? HS_POL : ~HS_POL;
            vs_pipe_d[0]    = vs_raw ? VS_POL : ~VS_POL;
            blank_pipe_d[0] = act;
            for (int i = 1; i <= PIPE_DEPTH; i++) begin
                hs_pipe_d[i]    = hs_pipe_q[i-1];
                vs_pipe_d[i]    = vs_pipe_q[i-1];
                blank_pipe_d[i] = blank_pipe_q[i-1];
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            x_q           <= '0;
            y_q           <= '0;
            col_q         <= '0;
            row_q         <= '0;
            active_q      <= 1'b0;
            pad_q         <= 1'b0;
            orequest_q    <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_count_q <= '0;
            hs_pipe_q     <= c_hs_idle;
            vs_pipe_q     <= c_vs_idle;
            blank_pipe_q  <= c_blank_idle;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            col_q         <= col_d;
            row_q         <= row_d;
            active_q      <= active_d;
            pad_q         <= pad_d;
            orequest_q    <= orequest_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            frame_count_q <= frame_count_d;
            hs_pipe_q     <= hs_pipe_d;
            vs_pipe_q     <= vs_pipe_d;
            blank_pipe_q  <= blank_pipe_d;
        end
    end

    assign VGA_HS      = hs_pipe_q[PIPE_DEPTH];
    assign VGA_VS      = vs_pipe_q[PIPE_DEPTH];
    assign VGA_BLANK_N = blank_pipe_q[PIPE_DEPTH];
    assign orequest    = orequest_q;
    assign col         = col_q;
    assign row         = row_q;
    assign active      = active_q;
    assign pad         = pad_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign frame_count = frame_count_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_gen
// Brief    : Randomised bench for vga_timing_gen against a step-index model
//            (x, y derived from the number of pixel steps taken).
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    localparam int HS = 4, HB = 5, HA = 12, HF = 3;
    localparam int VS = 2, VB = 3, VA = 8,  VF = 2;
    localparam int RL = 2, PD = 3, PADW = 2, CW = 13;
    localparam bit HPOL = 1'b0, VPOL = 1'b1;
    localparam int HT = HS + HB + HA + HF;
    localparam int VT = VS + VB + VA + VF;

    logic          clk = 1'b0;
    logic          rst_n, pix_ce, soft_clear;
    logic          vga_hs, vga_vs, vga_blank_n, orequest, active, pad;
    logic          line_start, frame_start;
    logic [CW-1:0] col, row;
    logic [15:0]   frame_count;

    int  n_chk = 0, n_err = 0;
    int  k = 0;        // pixel steps taken since the last reset / soft clear
    int  fc = 0;
    bit  ls_e = 1'b0, fs_e = 1'b0;

    vga_timing_gen #(
        .H_SYNC(HS), .H_BP(HB), .H_ACT(HA), .H_FP(HF),
        .V_SYNC(VS), .V_BP(VB), .V_ACT(VA), .V_FP(VF),
        .HS_POL(HPOL), .VS_POL(VPOL), .READ_LEAD(RL),
        .PIPE_DEPTH(PD), .PAD(PADW), .COORD_W(CW)
    ) dut (
        .CLOCK_50(clk), .RESET_N(rst_n), .pix_ce(pix_ce), .soft_clear(soft_clear),
        .VGA_HS(vga_hs), .VGA_VS(vga_vs), .VGA_BLANK_N(vga_blank_n),
        .orequest(orequest), .col(col), .row(row), .active(active), .pad(pad),
        .line_start(line_start), .frame_start(frame_start), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d step=%0d t=%0t", tag, got, exp, k, $time);
        end
    endtask

    function automatic int hx(input int idx); return idx % HT; endfunction
    function automatic int vy(input int idx); return (idx / HT) % VT; endfunction
    function automatic bit in_act(input int x, input int y);
        return (x >= HS + HB) && (x < HS + HB + HA) && (y >= VS + VB) && (y < VS + VB + VA);
    endfunction

    task automatic check_outputs();
        int x, y, cx, ry, px, py;
        bit a, e_pad, e_req, e_hs, e_vs, e_bl;
        a = 1'b0; cx = 0; ry = 0; e_pad = 1'b0; e_req = 1'b0;
        e_hs = !HPOL; e_vs = !VPOL; e_bl = 1'b0;
        if (k > 0) begin
            x = hx(k - 1);
            y = vy(k - 1);
            a = in_act(x, y);
            if (a) begin
                cx = x - (HS + HB);
                ry = y - (VS + VB);
                e_pad = (cx < PADW) || (cx >= HA - PADW) || (ry < PADW) || (ry >= VA - PADW);
            end
            e_req = in_act(x + RL, y);
        end
        if (k - 1 - PD >= 0) begin
            px = hx(k - 1 - PD);
            py = vy(k - 1 - PD);
            e_hs = (px < HS) ? HPOL : !HPOL;
            e_vs = (py < VS) ? VPOL : !VPOL;
            e_bl = in_act(px, py);
        end
        check("active",      int'(active),      int'(a));
        check("col",         int'(col),         cx);
        check("row",         int'(row),         ry);
        check("pad",         int'(pad),         int'(e_pad));
        check("orequest",    int'(orequest),    int'(e_req));
        check("VGA_HS",      int'(vga_hs),      int'(e_hs));
        check("VGA_VS",      int'(vga_vs),      int'(e_vs));
        check("VGA_BLANK_N", int'(vga_blank_n), int'(e_bl));
        check("line_start",  int'(line_start),  int'(ls_e));
        check("frame_start", int'(frame_start), int'(fs_e));
        check("frame_count", int'(frame_count), fc);
    endtask

    task automatic step_model(input bit ce, input bit sc);
        ls_e = 1'b0;
        fs_e = 1'b0;
        if (sc) begin
            k = 0;
        end else if (ce) begin
            ls_e = (hx(k) == 0);
            fs_e = ls_e && (vy(k) == 0);
            if (fs_e) fc = (fc + 1) % 65536;
            k++;
        end
    endtask

    task automatic cycle(input bit ce, input bit sc);
        pix_ce     = ce;
        soft_clear = sc;
        @(posedge clk);
        #1;
        step_model(ce, sc);
        check_outputs();
    endtask

    // Asynchronous reset pulse placed strictly between clock edges.
    task automatic async_reset();
        #3 rst_n = 1'b0;
        #1;
        k = 0; fc = 0; ls_e = 1'b0; fs_e = 1'b0;
        check_outputs();
        #1 rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; pix_ce = 1'b0; soft_clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        rst_n = 1'b1;

        // Continuous pixel steps across two full frames.
        repeat (2 * HT * VT + 50) cycle(1'b1, 1'b0);

        // Half-rate enable: outputs must hold and pulses stay one clock wide.
        for (int i = 0; i < 2 * HT * VT; i++) cycle(i % 2 == 0, 1'b0);

        // Soft clear mid-frame, held for three clocks.
        repeat (3) cycle(1'b1, 1'b1);
        repeat (HT * 7 + 9) cycle(1'b1, 1'b0);
        async_reset();

        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom % 4) != 0, ($urandom % 60) == 0);
            if (i == 1234 || ($urandom % 700) == 0) async_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised video timing generator and sync-alignment pipeline for the D8M camera-to-VGA path.
- Replaces the hard-coded counter compares at top level. Generates:
  - the horizontal/vertical counters;
  - the camera read request;
  - blanking;
  - the active-area row/col;
  - a border-padding flag for the 5x5 blur.
- Sync and blank are delayed by a programmable number of pixel steps so they align with pixels leaving the processing chain.

Parameters:
- H_SYNC, 96, hsync pulse width in pixels
- H_BP, 48, horizontal back porch
- H_ACT, 640, active pixels per line
- H_FP, 16, horizontal front porch
- V_SYNC, 2, vsync width in lines
- V_BP, 33, vertical back porch
- V_ACT, 480, active lines
- V_FP, 10, vertical front porch
- HS_POL, 0, hsync active level (0 = active low)
- VS_POL, 0, vsync active level
- READ_LEAD, 1, pixel steps orequest leads the active window; range 0..H_BP-1
- PIPE_DEPTH, 3, extra pixel-step delay applied to VGA_HS, VGA_VS and VGA_BLANK_N; range 0..15
- PAD, 2, border width flagged by pad
- COORD_W, 13, width of col/row

Ports:
- CLOCK_50 input 1: system clock
- RESET_N input 1: asynchronous active-low reset
- pix_ce input 1: pixel-step enable; the timing advances only when high
- soft_clear input 1: synchronous restart of the timing to x=0, y=0
- VGA_HS output 1: delayed hsync
- VGA_VS output 1: delayed vsync
- VGA_BLANK_N output 1: delayed blank, active low
- orequest output 1: camera FIFO read request
- col output COORD_W: active column, 0..H_ACT-1
- row output COORD_W: active row, 0..V_ACT-1
- active output 1: undelayed active-video flag
- pad output 1: active and inside the PAD-wide border
- line_start output 1: one-cycle pulse
- frame_start output 1: one-cycle pulse
- frame_count output 16: frames started since reset

Behaviour:
- Derived constants: H_TOT = H_SYNC+H_BP+H_ACT+H_FP (800 at defaults); V_TOT likewise (525 at defaults).
- Line layout: [sync][back porch][active][front porch], starting at x=0. Frame layout is the same in y.
- Counters x and y update only on cycles where pix_ce=1:
  - x increments and wraps from H_TOT-1 to 0;
  - on that wrap, y increments and wraps from V_TOT-1 to 0.
- All outputs are registered and change only on pix_ce cycles. The exceptions are line_start and frame_start, which are high for exactly one CLOCK_50 cycle.
- Raw signals (before the pipeline):
  - hs_raw = (x < H_SYNC); vs_raw = (y < V_SYNC);
  - act = x in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACT) and y in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACT).
- active, col, row, pad: registered one step after the counter state.
  - col = x - (H_SYNC+H_BP) and row = y - (V_SYNC+V_BP) when act; both are 0 otherwise.
  - pad = act and (col<PAD or col>=H_ACT-PAD or row<PAD or row>=V_ACT-PAD).
- orequest: registered; equals act evaluated at x+READ_LEAD within the same line, so it rises READ_LEAD steps before active and falls READ_LEAD steps before active ends. It is never high outside the V active lines.
- VGA_HS/VGA_VS: hs_raw/vs_raw mapped to the polarity parameters. They, and VGA_BLANK_N = act, pass through a PIPE_DEPTH-stage shift register clocked by pix_ce. Total latency from counter state to pin is 1+PIPE_DEPTH steps.
- line_start: pulses on the pix_ce cycle where x==0 is registered.
- frame_start: pulses when x==0 and y==0; frame_count increments on the same cycle and wraps 0xFFFF to 0.
- Reset (asynchronous, RESET_N=0):
  - x=y=0; col, row, pad, active, orequest, line_start, frame_start and frame_count all 0;
  - VGA_BLANK_N=0;
  - VGA_HS/VGA_VS and every pipeline stage at the inactive level (1 at defaults).
  - The first pix_ce after release registers x=0,y=0, so line_start and frame_start pulse and frame_count becomes 1.
- soft_clear (sampled every clock regardless of pix_ce):
  - forces x=y=0 and flushes the pipeline to inactive/blanked;
  - frame_count is kept;
  - it takes priority over a simultaneous pix_ce advance.
  - The first pix_ce after it is released behaves as the post-reset start.
- pix_ce held low: all state freezes; pulses are not repeated.

Test Plan:
- Reset, then pix_ce=1 continuously at defaults:
  - line_start every 800 clocks; frame_start every 420000 clocks;
  - VGA_HS low for 96 of every 800 steps, first low at step 1+PIPE_DEPTH.
- Defaults, during line y=35:
  - orequest rises at the step registering x=143;
  - active rises at x=144 with col=0; col=639 at x=783;
  - active falls at x=784.
- pad at PAD=2:
  - high for row 0,1,478,479 and for col 0,1,638,639;
  - low at (row=2,col=2) and at (row=477,col=637).
- pix_ce toggling 1,0 (25 MHz rate):
  - line period 1600 clocks;
  - outputs hold while pix_ce=0;
  - pulses last one clock.
- soft_clear asserted mid-line (x=400, y=200) for 3 clocks:
  - outputs go blanked/inactive;
  - the next pix_ce registers x=0,y=0 and frame_start pulses;
  - frame_count increments from its held value.
- RESET_N pulsed low asynchronously between clock edges mid-frame: all outputs immediately take their reset values; frame_count=0.
